// File: rtl/sram_rr_arbiter_pkg.sv
// Shared SoC definitions: arbiter FSM states, byte-enable width and default master count.
package soc_pkg;

    localparam int DEFAULT_N_MASTERS  = 4;
    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int BE_WIDTH           = DEFAULT_DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/sram_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: the lowest requesting index at or above ptr wins,
// otherwise the lowest requesting index below ptr.
module rr_pick #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] winner,
    output logic          found
);

    always_comb begin
        winner = '0;
        found  = 1'b0;
        // Wrapped-around half first so the at-or-above-ptr half overrides it.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i] && (IW'(i) < ptr)) begin
                winner = IW'(i);
                found  = 1'b1;
            end
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i] && (IW'(i) >= ptr)) begin
                winner = IW'(i);
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sram_rr_arbiter.sv
// Round-robin arbiter sharing one req/gnt/rvalid slave port among N_MASTERS cores,
// one outstanding transaction, responses routed back to the issuing master.
module sram_rr_arbiter
    import soc_pkg::*;
#(
    parameter  int N_MASTERS  = DEFAULT_N_MASTERS,
    parameter  int DATA_WIDTH = 32,
    parameter  int ADDR_WIDTH = 32,
    localparam int IDX_BITS   = $clog2(N_MASTERS)
) (
    input  logic                                  clk,
    input  logic                                  resetn,
    input  logic [N_MASTERS-1:0]                  m_req_i,
    input  logic [N_MASTERS-1:0]                  m_we_i,
    input  logic [N_MASTERS-1:0][BE_WIDTH-1:0]    m_be_i,
    input  logic [N_MASTERS-1:0][ADDR_WIDTH-1:0]  m_addr_i,
    input  logic [N_MASTERS-1:0][DATA_WIDTH-1:0]  m_wdata_i,
    output logic [N_MASTERS-1:0]                  m_gnt_o,
    output logic [N_MASTERS-1:0]                  m_rvalid_o,
    output logic [N_MASTERS-1:0][DATA_WIDTH-1:0]  m_rdata_o,
    output logic                                  s_req_o,
    output logic                                  s_we_o,
    output logic [BE_WIDTH-1:0]                   s_be_o,
    output logic [ADDR_WIDTH-1:0]                 s_addr_o,
    output logic [DATA_WIDTH-1:0]                 s_wdata_o,
    input  logic                                  s_gnt_i,
    input  logic                                  s_rvalid_i,
    input  logic [DATA_WIDTH-1:0]                 s_rdata_i,
    output logic [IDX_BITS-1:0]                   owner_o
);

    arb_state_e                                  state;
    logic [IDX_BITS-1:0]                         owner, rr_ptr, ptr_nxt;
    logic [IDX_BITS-1:0]                         pick_idx, pick_ptr;
    logic [N_MASTERS-1:0]                        pick_req, owner_oh;
    logic                                        pick_found;
    logic [N_MASTERS-1:0][DATA_WIDTH-1:0]        rdata_q;

    always_comb begin
        ptr_nxt = (owner == IDX_BITS'(N_MASTERS - 1)) ? '0 : owner + 1'b1;
    end

    // In RESP the owner's request is stale (it cannot re-request before rvalid),
    // so it is masked and the search starts just past the owner.
    assign pick_req = (state == RESP) ? (m_req_i & ~owner_oh) : m_req_i;
    assign pick_ptr = (state == RESP) ? ptr_nxt : rr_ptr;

    rr_pick #(.N(N_MASTERS)) u_pick (
        .req    (pick_req),
        .ptr    (pick_ptr),
        .winner (pick_idx),
        .found  (pick_found)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            owner     <= '0;
            s_we_o    <= 1'b0;
            s_be_o    <= '0;
            s_addr_o  <= '0;
            s_wdata_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        owner     <= pick_idx;
                        s_we_o    <= m_we_i[pick_idx];
                        s_be_o    <= m_be_i[pick_idx];
                        s_addr_o  <= m_addr_i[pick_idx];
                        s_wdata_o <= m_wdata_i[pick_idx];
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (s_gnt_i) state <= RESP;
                end
                RESP: begin
                    if (s_rvalid_i) begin
                        rr_ptr <= ptr_nxt;
                        if (pick_found) begin
                            owner     <= pick_idx;
                            s_we_o    <= m_we_i[pick_idx];
                            s_be_o    <= m_be_i[pick_idx];
                            s_addr_o  <= m_addr_i[pick_idx];
                            s_wdata_o <= m_wdata_i[pick_idx];
                            state     <= ISSUE;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdata_q <= '0;
        end else begin
            for (int i = 0; i < N_MASTERS; i++)
                if (m_rvalid_o[i]) rdata_q[i] <= s_rdata_i;
        end
    end

    assign s_req_o = (state == ISSUE);
    assign owner_o = owner;

    for (genvar i = 0; i < N_MASTERS; i++) begin : g_master
        assign owner_oh[i]   = (owner == IDX_BITS'(i));
        assign m_gnt_o[i]    = (state == ISSUE) & s_gnt_i & owner_oh[i];
        assign m_rvalid_o[i] = (state == RESP) & s_rvalid_i & owner_oh[i];
        // Live pass-through on the response cycle, last delivered word otherwise.
        assign m_rdata_o[i]  = m_rvalid_o[i] ? s_rdata_i : rdata_q[i];
    end

endmodule

// File: doc/sram_rr_arbiter.md
Name: sram_rr_arbiter

Overview:
- Round-robin arbiter that shares one single-ported SRAM/peripheral slave port between N_MASTERS cores.
- Uses the req/gnt/rvalid handshake of the SoC interconnect on both sides.
- Sits between the core-side memory buses and the on-chip BRAM slave, with at most one outstanding transaction.
- Routes each response back to the master that issued the request.

Parameters:
- N_MASTERS, 4, number of requesting masters (2..8).
- DATA_WIDTH, 32, data bus width in bits.
- ADDR_WIDTH, 32, address bus width in bits.
- IDX_BITS, $clog2(N_MASTERS), width of the master index (derived; not overridden).

Ports:
- clk  in  1  system clock.
- resetn  in  1  reset; asynchronous, active-low.
- m_req_i  in  N_MASTERS  per-master request; held high until granted.
- m_we_i  in  N_MASTERS  per-master write enable.
- m_be_i  in  4*N_MASTERS  per-master byte enables.
- m_addr_i  in  ADDR_WIDTH*N_MASTERS  per-master address.
- m_wdata_i  in  DATA_WIDTH*N_MASTERS  per-master write data.
- m_gnt_o  out  N_MASTERS  one-cycle grant pulse; request accepted.
- m_rvalid_o  out  N_MASTERS  one-cycle response pulse.
- m_rdata_o  out  DATA_WIDTH*N_MASTERS  read data; valid when the matching rvalid is high.
- s_req_o  out  1  slave request.
- s_we_o  out  1  slave write enable.
- s_be_o  out  4  slave byte enables.
- s_addr_o  out  ADDR_WIDTH  slave address.
- s_wdata_o  out  DATA_WIDTH  slave write data.
- s_gnt_i  in  1  slave accepts the request this cycle.
- s_rvalid_i  in  1  slave response valid.
- s_rdata_i  in  DATA_WIDTH  slave read data.
- owner_o  out  IDX_BITS  index of the master currently or last served (debug).

Behaviour:
Reset (asynchronous, resetn low):
- FSM goes to IDLE; rr_ptr=0; owner_o=0.
- All gnt, rvalid and s_req outputs are 0; s_we_o, s_be_o, s_addr_o, s_wdata_o are 0.
- Registered m_rdata_o is 0.

FSM:
- IDLE -> ISSUE when any m_req_i is high.
  - Winner = first requesting index scanning rr_ptr, rr_ptr+1, ... modulo N_MASTERS.
  - Winner's we/be/addr/wdata are captured into registers; owner_o <= winner.
- ISSUE: s_req_o=1 and the s_* outputs are driven from the registers.
  - If s_gnt_i=1: m_gnt_o[owner] pulses high for exactly this cycle; go to RESP.
  - Otherwise hold; the captured request must not change.
- RESP: s_req_o=0.
  - When s_rvalid_i=1: m_rvalid_o[owner]=1 and m_rdata_o[owner] = s_rdata_i for that cycle (combinational pass-through); rr_ptr <= owner+1 (wraps to 0 after N_MASTERS-1).
  - If any m_req_i is high excluding the owner's stale request, arbitrate immediately and go to ISSUE (back-to-back); else go to IDLE.
  - The owner's stale request is excluded only in that cycle, because the owner cannot issue a new request until after rvalid.
- Writes also complete with an rvalid pulse; rdata is don't-care for writes but is still passed through.

Latency:
- With a slave that asserts gnt and rvalid constantly: req seen in cycle 0 -> gnt in cycle 1 -> rvalid in cycle 2.
- Sustained throughput: one transaction per 2 cycles.

Boundary conditions:
- All masters requesting: strict rotation 0,1,2,3,0,...; no master waits more than N_MASTERS-1 transactions.
- A request dropped by a master before gnt is a protocol violation; the arbiter still completes the captured transaction and delivers rvalid to the owner.
- s_rvalid_i while in IDLE or ISSUE is ignored.
- s_gnt_i while in IDLE or RESP is ignored.
- Only one of m_gnt_o and only one of m_rvalid_o is ever high in any cycle; these are one-hot-or-zero invariants.
- Reset mid-transaction: state is lost immediately and all outputs return to their reset values; no rvalid is issued for the aborted transaction.
- rr_ptr arithmetic is modulo N_MASTERS, including non-power-of-two values.

Decomposition:
- Shared package soc_pkg holds:
  - the FSM state enum (IDLE, ISSUE, RESP; 2 bits);
  - localparam BE_WIDTH=DATA_WIDTH/8;
  - the default N_MASTERS.
- One sub-module, rr_pick: combinational round-robin priority picker.
  - Inputs: req vector and rr_ptr. Outputs: winner index and found flag.
  - Reused by the future interconnect.

Test Plan:
- Single read, master 2, addr 0x00000010; slave returns 0xDEADBEEF with gnt and rvalid tied high -> m_gnt_o=4'b0100 in cycle 1; m_rvalid_o=4'b0100 and m_rdata_o[2]=0xDEADBEEF in cycle 2; other rvalid bits 0.
- All 4 masters request writes continuously (be=4'hF, addr=0x100+i) -> slave sees addr order 0x100, 0x101, 0x102, 0x103, 0x100; one gnt every 2 cycles.
- Slave stalls s_gnt_i low for 5 cycles while master 1 requests -> s_req_o and s_addr_o held stable for 5 cycles; m_gnt_o[1] pulses only in the cycle s_gnt_i rises.
- rr_ptr=3 with masters 0 and 2 requesting -> master 0 granted first, then master 2.
- resetn pulsed low during RESP of a master-3 read -> no m_rvalid_o pulse; all outputs 0 while reset is low; next request from master 0 is served normally.
- N_MASTERS=3 build, all requesting -> order 0,1,2,0; owner_o never exceeds 2.
